apb_rw_regs: RTL and testbench

APB4 slave register file with NoApbRegs 32-bit-aligned registers starting at a runtime base address.
- Supports byte-strobed writes, a per-register read-only mask and a programmable number of wait states.
- Provides a hardware load port that updates registers from the fabric side.
- Serves as the general-purpose control/status register block on peripheral APB buses, replacing hand-written register banks.

---
 rtl/apb_rw_regs.sv | 148 ++++++++++++++
 tb/tb_apb_rw_regs.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_rw_regs.sv
// APB4 slave register file: byte-strobed writes, per-register read-only mask,
// fixed wait states and a fabric-side hardware load port.

package apb_rw_regs_pkg;
    typedef struct packed {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;
endpackage

module apb_rw_regs #(
    parameter int unsigned NoApbRegs    = 1,
    parameter int unsigned ApbAddrWidth = 32,
    parameter int unsigned ApbDataWidth = 32,
    parameter int unsigned RegDataWidth = 32,
    parameter logic [NoApbRegs-1:0] ReadOnlyMask = '0,
    parameter logic [NoApbRegs*RegDataWidth-1:0] RegRstVal = '0,
    parameter int unsigned WaitCycles   = 0,
    parameter type req_t  = apb_rw_regs_pkg::apb_req_t,
    parameter type resp_t = apb_rw_regs_pkg::apb_resp_t
) (
    input  logic                                       pclk_i,
    input  logic                                       preset_i,
    input  req_t                                       req_i,
    output resp_t                                      resp_o,
    input  logic [ApbAddrWidth-1:0]                    base_addr_i,
    input  logic [NoApbRegs-1:0]                       reg_load_i,
    input  logic [NoApbRegs-1:0][RegDataWidth-1:0]     reg_d_i,
    output logic [NoApbRegs-1:0][RegDataWidth-1:0]     reg_q_o,
    output logic [NoApbRegs-1:0]                       reg_wr_o
);

    localparam int unsigned NumBytes = ApbDataWidth / 8;
    localparam int unsigned IdxW     = (NoApbRegs > 1) ? $clog2(NoApbRegs) : 1;
    localparam logic [ApbAddrWidth-1:0] Span = ApbAddrWidth'(4 * NoApbRegs);
    localparam logic [31:0] BadData = 32'h0BAD_B10C;

    if (NoApbRegs < 1) begin : g_err_regs
        $error("NoApbRegs must be >= 1");
    end
    if (RegDataWidth > ApbDataWidth || ApbDataWidth > 32) begin : g_err_width
        $error("require RegDataWidth <= ApbDataWidth <= 32");
    end
    if ($bits(req_i.paddr) != ApbAddrWidth) begin : g_err_paddr
        $error("paddr width must equal ApbAddrWidth");
    end
    if ($bits(req_i.pstrb) != ApbDataWidth / 8) begin : g_err_pstrb
        $error("pstrb width must equal ApbDataWidth/8");
    end
    if (WaitCycles > 15) begin : g_err_wait
        $error("WaitCycles must be <= 15");
    end

    logic [NoApbRegs-1:0][RegDataWidth-1:0] reg_q;
    logic [NoApbRegs-1:0]                   reg_wr_q;
    logic [3:0]                             cnt_q;
    logic [ApbAddrWidth-1:0]                offset;
    logic [IdxW-1:0]                        idx;
    logic                                   addr_ok;
    logic                                   read_only;
    logic                                   pready;
    logic [ApbDataWidth-1:0]                wmask;
    logic [NoApbRegs-1:0]                   wr_sel;
    logic                                   unused_bits;

    assign unused_bits = ^req_i.pprot;

    // Address decode and wait-state gated completion.
    always_comb begin
        offset    = req_i.paddr - base_addr_i;
        idx       = offset[IdxW+1:2];
        addr_ok   = (req_i.paddr >= base_addr_i) && (offset < Span);
        read_only = addr_ok && ReadOnlyMask[idx];
        pready    = !preset_i && req_i.psel && req_i.penable && (cnt_q == 4'(WaitCycles));
    end

    // Byte-strobe expansion and one-hot select of the register being committed.
    always_comb begin
        wmask  = '0;
        wr_sel = '0;
        for (int unsigned b = 0; b < NumBytes; b++) begin
            wmask[8*b +: 8] = {8{req_i.pstrb[b]}};
        end
        if (pready && req_i.pwrite && addr_ok && !read_only) begin
            wr_sel[idx] = 1'b1;
        end
    end

    // Response: only driven during the pready cycle, zero otherwise.
    always_comb begin
        resp_o = '0;
        resp_o.pready = pready;
        if (pready) begin
            if (req_i.pwrite) begin
                resp_o.pslverr = !addr_ok || read_only;
            end else if (addr_ok) begin
                resp_o.prdata[RegDataWidth-1:0] = reg_q[idx];
            end else begin
                resp_o.prdata  = BadData[ApbDataWidth-1:0];
                resp_o.pslverr = 1'b1;
            end
        end
    end

    // Wait-state counter: counts access-phase cycles, clears on completion or idle.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            cnt_q <= '0;
        end else if (!req_i.psel || pready) begin
            cnt_q <= '0;
        end else if (req_i.penable) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Register storage: hardware load takes priority over an APB write commit.
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            reg_q    <= RegRstVal;
            reg_wr_q <= '0;
        end else begin
            reg_wr_q <= wr_sel;
            for (int unsigned i = 0; i < NoApbRegs; i++) begin
                if (reg_load_i[i]) begin
                    reg_q[i] <= reg_d_i[i];
                end else if (wr_sel[i]) begin
                    reg_q[i] <= (reg_q[i] & ~wmask[RegDataWidth-1:0])
                              | (req_i.pwdata[RegDataWidth-1:0] & wmask[RegDataWidth-1:0]);
                end
            end
        end
    end

    assign reg_q_o  = reg_q;
    assign reg_wr_o = reg_wr_q;

endmodule

// File: tb/tb_apb_rw_regs.sv
// Directed bench for apb_rw_regs: 4 registers at 0x1000, reg3 read-only,
// two wait states; a second instance with no wait states shares the bus.

module tb_apb_rw_regs;
    import apb_rw_regs_pkg::*;

    localparam logic [3:0][31:0] RstVal = {32'hC3C3_0003, 32'h1234_5678, 32'h0000_0000, 32'hA5A5_0000};

    logic             clk;
    logic             preset;
    apb_req_t         req;
    apb_resp_t        resp, resp0;
    logic [31:0]      base;
    logic [3:0]       reg_load;
    logic [3:0][31:0] reg_d;
    logic [3:0][31:0] reg_q, reg_q0;
    logic [3:0]       reg_wr, reg_wr0;

    int n_checks = 0;
    int n_errs   = 0;

    apb_rw_regs #(
        .NoApbRegs(4), .ApbAddrWidth(32), .ApbDataWidth(32), .RegDataWidth(32),
        .ReadOnlyMask(4'b1000), .RegRstVal(RstVal), .WaitCycles(2),
        .req_t(apb_req_t), .resp_t(apb_resp_t)
    ) dut (
        .pclk_i(clk), .preset_i(preset), .req_i(req), .resp_o(resp),
        .base_addr_i(base), .reg_load_i(reg_load), .reg_d_i(reg_d),
        .reg_q_o(reg_q), .reg_wr_o(reg_wr)
    );

    apb_rw_regs #(
        .NoApbRegs(4), .ApbAddrWidth(32), .ApbDataWidth(32), .RegDataWidth(32),
        .ReadOnlyMask(4'b1000), .RegRstVal(RstVal), .WaitCycles(0),
        .req_t(apb_req_t), .resp_t(apb_resp_t)
    ) dut0 (
        .pclk_i(clk), .preset_i(preset), .req_i(req), .resp_o(resp0),
        .base_addr_i(base), .reg_load_i(reg_load), .reg_d_i(reg_d),
        .reg_q_o(reg_q0), .reg_wr_o(reg_wr0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Full APB transfer; ld is driven on reg_load_i during the pready cycle.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [3:0] ld,
                            output logic [31:0] rdata, output logic err, output int waits);
        logic done;
        done  = 1'b0;
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        @(posedge clk); #1;
        req.psel = 1'b1; req.penable = 1'b0; req.pwrite = wr;
        req.paddr = addr; req.pwdata = wdata; req.pstrb = strb; req.pprot = '0;
        @(posedge clk); #1;
        req.penable = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (resp.pready) begin
                rdata    = resp.prdata;
                err      = resp.pslverr;
                reg_load = ld;
                done     = 1'b1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        check_eq("pready_seen", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        req.psel = 1'b0; req.penable = 1'b0; reg_load = '0;
    endtask

    logic [31:0] rdata;
    logic        err;
    int          waits;

    initial begin
        preset   = 1'b1;
        req      = '0;
        base     = 32'h1000;
        reg_load = '0;
        reg_d    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pready", {31'b0, resp.pready}, 32'd0);
        preset = 1'b0;
        @(negedge clk);
        check_eq("rst_wr", {28'b0, reg_wr}, 32'd0);
        check_eq("rst_cnt", {28'b0, dut.cnt_q}, 32'd0);
        check_eq("rst_q2", reg_q[2], 32'h1234_5678);

        // Reset values read back with two wait states each
        for (int i = 0; i < 4; i++) begin
            apb_xfer(1'b0, 32'h1000 + 32'(4*i), 32'h0, 4'h0, 4'h0, rdata, err, waits);
            check_eq($sformatf("rst_rd%0d", i), rdata, RstVal[i]);
            check_eq($sformatf("rst_err%0d", i), {31'b0, err}, 32'd0);
            check_eq($sformatf("rst_waits%0d", i), 32'(waits), 32'd2);
        end

        // Strobed write: bytes 0 and 2 only
        apb_xfer(1'b1, 32'h1004, 32'hDEAD_BEEF, 4'b0101, 4'h0, rdata, err, waits);
        check_eq("wr1_err", {31'b0, err}, 32'd0);
        check_eq("wr1_q", reg_q[1], 32'h00AD_00EF);
        check_eq("wr1_pulse", {28'b0, reg_wr}, 32'h2);
        @(posedge clk); #1;
        check_eq("wr1_pulse_end", {28'b0, reg_wr}, 32'h0);
        apb_xfer(1'b0, 32'h1006, 32'h0, 4'h0, 4'h0, rdata, err, waits);
        check_eq("wr1_rdback", rdata, 32'h00AD_00EF);

        // Read-only write, out-of-range read and below-base write
        apb_xfer(1'b1, 32'h100C, 32'hFFFF_FFFF, 4'hF, 4'h0, rdata, err, waits);
        check_eq("ro_err", {31'b0, err}, 32'd1);
        check_eq("ro_q3", reg_q[3], 32'hC3C3_0003);
        check_eq("ro_pulse", {28'b0, reg_wr}, 32'h0);
        apb_xfer(1'b0, 32'h1010, 32'h0, 4'h0, 4'h0, rdata, err, waits);
        check_eq("oor_err", {31'b0, err}, 32'd1);
        check_eq("oor_data", rdata, 32'h0BAD_B10C);
        apb_xfer(1'b1, 32'h0FFC, 32'h0, 4'hF, 4'h0, rdata, err, waits);
        check_eq("below_err", {31'b0, err}, 32'd1);
        check_eq("below_pulse", {28'b0, reg_wr}, 32'h0);

        // Zero strobes: OKAY, unchanged, still pulses
        apb_xfer(1'b1, 32'h1008, 32'hFFFF_FFFF, 4'h0, 4'h0, rdata, err, waits);
        check_eq("nostrb_err", {31'b0, err}, 32'd0);
        check_eq("nostrb_q2", reg_q[2], 32'h1234_5678);
        check_eq("nostrb_pulse", {28'b0, reg_wr}, 32'h4);

        // Hardware load coinciding with APB commit wins
        reg_d[0] = 32'h2222_2222;
        apb_xfer(1'b1, 32'h1000, 32'h1111_1111, 4'hF, 4'b0001, rdata, err, waits);
        check_eq("hwld_err", {31'b0, err}, 32'd0);
        check_eq("hwld_q0", reg_q[0], 32'h2222_2222);
        check_eq("hwld_pulse", {28'b0, reg_wr}, 32'h1);

        // psel dropped during a wait state
        @(posedge clk); #1;
        req.psel = 1'b1; req.penable = 1'b0; req.pwrite = 1'b1;
        req.paddr = 32'h1008; req.pwdata = 32'hFFFF_FFFF; req.pstrb = 4'hF;
        @(posedge clk); #1;
        req.penable = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_cnt1", {28'b0, dut.cnt_q}, 32'd1);
        @(posedge clk); #1;
        req.psel = 1'b0;
        @(negedge clk);
        check_eq("abort_pready", {31'b0, resp.pready}, 32'd0);
        @(posedge clk); #1;
        req.penable = 1'b0;
        check_eq("abort_cnt0", {28'b0, dut.cnt_q}, 32'd0);
        check_eq("abort_q2", reg_q[2], 32'h1234_5678);
        check_eq("abort_pulse", {28'b0, reg_wr}, 32'h0);
        apb_xfer(1'b0, 32'h1008, 32'h0, 4'h0, 4'h0, rdata, err, waits);
        check_eq("abort_waits", 32'(waits), 32'd2);
        check_eq("abort_rd", rdata, 32'h1234_5678);

        // Reset during the would-be pready cycle of a write
        @(posedge clk); #1;
        req.psel = 1'b1; req.penable = 1'b0; req.pwrite = 1'b1;
        req.paddr = 32'h1004; req.pwdata = 32'h5555_5555; req.pstrb = 4'hF;
        @(posedge clk); #1;
        req.penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        preset = 1'b1;
        @(negedge clk);
        check_eq("rstmid_pready", {31'b0, resp.pready}, 32'd0);
        @(posedge clk); #1;
        check_eq("rstmid_cnt", {28'b0, dut.cnt_q}, 32'd0);
        check_eq("rstmid_q1", reg_q[1], 32'h0000_0000);
        check_eq("rstmid_q0", reg_q[0], 32'hA5A5_0000);
        check_eq("rstmid_pulse", {28'b0, reg_wr}, 32'h0);
        preset = 1'b0; req.psel = 1'b0; req.penable = 1'b0;

        // No-wait-state instance completes in the first access-phase cycle
        @(posedge clk); #1;
        req.psel = 1'b1; req.penable = 1'b0; req.pwrite = 1'b0; req.paddr = 32'h1008;
        @(negedge clk);
        check_eq("w0_setup_pready", {31'b0, resp0.pready}, 32'd0);
        @(posedge clk); #1;
        req.penable = 1'b1;
        @(negedge clk);
        check_eq("w0_pready", {31'b0, resp0.pready}, 32'd1);
        check_eq("w0_rd", resp0.prdata, 32'h1234_5678);
        check_eq("w2_not_ready", {31'b0, resp.pready}, 32'd0);
        @(posedge clk); #1;
        req.psel = 1'b0; req.penable = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
